// File: rtl/seg_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg_scan_decoder                                             |
// | Description : Recovers an 8-digit value from a multiplexed 7-segment scan. |
// |               Locks on digit7, collects digits 7..0 into a shadow word and |
// |               publishes complete frames. Protocol errors and long blank    |
// |               runs drop lock.                                              |
// | Options     : SEG_SCAN_DECODER_ERRCNT_EN builds a saturating error counter |
// |               on o_err_cnt; otherwise o_err_cnt is tied to 8'h00.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg_scan_decoder #(
  parameter int IDLE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pls_1k,
  input  logic [7:0]  i_seg_d,
  input  logic [7:0]  i_seg_com,
  output logic [31:0] o_bcd8d,
  output logic        o_frame_vld,
  output logic        o_lock,
  output logic        o_err,
  output logic [7:0]  o_err_cnt
);

  localparam int               c_BW        = $clog2(IDLE_LIMIT + 1);
  localparam logic [c_BW-1:0]  c_IDLE_LIM  = c_BW'(IDLE_LIMIT);

  typedef enum logic [0:0] {
    ST_SYNC    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_exp_idx;
  logic [2:0]        w_exp_idx_nxt;
  logic [c_BW-1:0]   r_blank_cnt;
  logic [c_BW-1:0]   w_blank_cnt_nxt;
  logic [c_BW-1:0]   w_blank_inc;
  logic [31:0]       r_shadow;
  logic [31:0]       w_shadow_nxt;
  logic              w_load;
  logic              w_err;

  logic [31:0]       r_bcd8d;
  logic              r_frame_vld;
  logic              r_lock;
  logic              r_err;

  logic [3:0]        w_nib;
  logic              w_known;
  logic              w_blank;
  logic              w_onehot;
  logic [2:0]        w_idx;

  // The dot segment carries no digit information.
  logic              w_unused_dot;
  assign w_unused_dot = i_seg_d[7];

  // Segment pattern to nibble; anything outside the table is unknown.
  always_comb begin
    w_nib   = 4'h0;
    w_known = 1'b1;
    case (i_seg_d[6:0])
      7'h3f:   w_nib = 4'h0;
      7'h06:   w_nib = 4'h1;
      7'h5b:   w_nib = 4'h2;
      7'h4f:   w_nib = 4'h3;
      7'h66:   w_nib = 4'h4;
      7'h6d:   w_nib = 4'h5;
      7'h7d:   w_nib = 4'h6;
      7'h27:   w_nib = 4'h7;
      7'h7f:   w_nib = 4'h8;
      7'h6f:   w_nib = 4'h9;
      7'h08:   w_nib = 4'ha;
      7'h00:   w_nib = 4'hb;
      7'h79:   w_nib = 4'hc;
      7'h77:   w_nib = 4'hd;
      default: w_known = 1'b0;
    endcase
  end

  // Common classification; scan index 0 is digit7 (bit 7) down to 7 = digit0.
  always_comb begin
    w_blank  = (i_seg_com == 8'h00);
    w_onehot = !w_blank && ((i_seg_com & (i_seg_com - 8'd1)) == 8'h00);
    w_idx    = 3'd0;
    for (int p = 0; p < 8; p++) begin
      if (i_seg_com[p]) w_idx = 3'(7 - p);
    end
  end

  assign w_blank_inc = r_blank_cnt + c_BW'(1);

  // Next-state, shadow update and pulse generation for one strobe sample.
  always_comb begin
    w_state_nxt     = r_state;
    w_exp_idx_nxt   = r_exp_idx;
    w_blank_cnt_nxt = r_blank_cnt;
    w_shadow_nxt    = r_shadow;
    w_load          = 1'b0;
    w_err           = 1'b0;
    if (i_pls_1k) begin
      case (r_state)
        ST_SYNC: begin
          if (w_onehot && (w_idx == 3'd0) && w_known) begin
            w_shadow_nxt[31:28] = w_nib;
            w_exp_idx_nxt       = 3'd1;
            w_blank_cnt_nxt     = '0;
            w_state_nxt         = ST_COLLECT;
          end
        end
        default: begin
          if (w_blank) begin
            if (w_blank_inc == c_IDLE_LIM) begin
              w_state_nxt     = ST_SYNC;
              w_exp_idx_nxt   = 3'd0;
              w_blank_cnt_nxt = '0;
            end else begin
              w_blank_cnt_nxt = w_blank_inc;
            end
          end else if (!w_onehot || (w_idx != r_exp_idx) || !w_known) begin
            // The offending sample is dropped, never reused as a start.
            w_err           = 1'b1;
            w_state_nxt     = ST_SYNC;
            w_exp_idx_nxt   = 3'd0;
            w_blank_cnt_nxt = '0;
          end else begin
            for (int i = 0; i < 8; i++) begin
              if (r_exp_idx == 3'(i)) w_shadow_nxt[31-4*i -: 4] = w_nib;
            end
            w_blank_cnt_nxt = '0;
            w_exp_idx_nxt   = r_exp_idx + 3'd1;
            w_load          = (r_exp_idx == 3'd7);
          end
        end
      endcase
    end
  end

  // FSM and scan bookkeeping registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_SYNC;
      r_exp_idx   <= 3'd0;
      r_blank_cnt <= '0;
      r_shadow    <= 32'h0;
    end else begin
      r_state     <= w_state_nxt;
      r_exp_idx   <= w_exp_idx_nxt;
      r_blank_cnt <= w_blank_cnt_nxt;
      r_shadow    <= w_shadow_nxt;
    end
  end

  // Published frame, lock flag and one-cycle pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bcd8d     <= 32'h0;
      r_frame_vld <= 1'b0;
      r_lock      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_load) r_bcd8d <= w_shadow_nxt;
      r_frame_vld <= w_load;
      r_lock      <= (w_state_nxt == ST_COLLECT);
      r_err       <= w_err;
    end
  end

  assign o_bcd8d     = r_bcd8d;
  assign o_frame_vld = r_frame_vld;
  assign o_lock      = r_lock;
  assign o_err       = r_err;

`ifdef SEG_SCAN_DECODER_ERRCNT_EN
  logic [7:0] r_err_cnt;

  // Saturating count of protocol errors, updated alongside o_err.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err_cnt <= 8'h00;
    end else if (w_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign o_err_cnt = r_err_cnt;
`else
  assign o_err_cnt = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seg_scan_decoder                                          |
// | Description : Directed self-checking bench for seg_scan_decoder.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seg_scan_decoder;

`ifdef SEG_SCAN_DECODER_ERRCNT_EN
  localparam int c_CNT_ON = 1;
`else
  localparam int c_CNT_ON = 0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_pls_1k;
  logic [7:0]  i_seg_d;
  logic [7:0]  i_seg_com;
  logic [31:0] o_bcd8d;
  logic        o_frame_vld;
  logic        o_lock;
  logic        o_err;
  logic [7:0]  o_err_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic r_any_err;

  seg_scan_decoder #(.IDLE_LIMIT(4)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_pls_1k    (i_pls_1k),
    .i_seg_d     (i_seg_d),
    .i_seg_com   (i_seg_com),
    .o_bcd8d     (o_bcd8d),
    .o_frame_vld (o_frame_vld),
    .o_lock      (o_lock),
    .o_err       (o_err),
    .o_err_cnt   (o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 8'h3f;
      4'h1: return 8'h06;
      4'h2: return 8'h5b;
      4'h3: return 8'h4f;
      4'h4: return 8'h66;
      4'h5: return 8'h6d;
      4'h6: return 8'h7d;
      4'h7: return 8'h27;
      4'h8: return 8'h7f;
      4'h9: return 8'h6f;
      4'ha: return 8'h08;
      4'hb: return 8'h00;
      4'hc: return 8'h79;
      4'hd: return 8'h77;
      default: return 8'h55;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One strobed sample; outputs are settled when this returns.
  task automatic sample(input logic [7:0] seg, input logic [7:0] com);
    @(negedge i_clk);
    i_seg_d   = seg;
    i_seg_com = com;
    i_pls_1k  = 1'b1;
    @(posedge i_clk);
    #1;
    i_pls_1k  = 1'b0;
    i_seg_d   = 8'h55;
    i_seg_com = 8'h81;
    r_any_err = r_any_err | o_err;
  endtask

  task automatic send_digit(input int d, input logic [3:0] n, input logic dot);
    sample(seg7(n) | {dot, 7'b0}, 8'h01 << d);
  endtask

  task automatic send_frame(input logic [31:0] w);
    for (int d = 7; d >= 0; d--) send_digit(d, w[4*d +: 4], 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bcd"}, o_bcd8d, 32'h0);
    chk({tag, "_vld"}, {31'b0, o_frame_vld}, 32'h0);
    chk({tag, "_lock"}, {31'b0, o_lock}, 32'h0);
    chk({tag, "_err"}, {31'b0, o_err}, 32'h0);
    chk({tag, "_cnt"}, {24'b0, o_err_cnt}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_pls_1k = 1'b0; i_seg_d = 8'h00; i_seg_com = 8'h00;
    r_any_err = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk_all_zero("reset");
    @(negedge i_clk) i_rst = 1'b0;

    // Full frame 12345678 with dot bits set.
    send_digit(7, 4'h1, 1'b1);
    chk("t1_lock_d7", {31'b0, o_lock}, 32'h1);
    for (int d = 6; d >= 1; d--) send_digit(d, 4'(8 - d), 1'b1);
    chk("t1_novld_d1", {31'b0, o_frame_vld}, 32'h0);
    chk("t1_bcd_pre", o_bcd8d, 32'h0);
    send_digit(0, 4'h8, 1'b1);
    chk("t1_vld", {31'b0, o_frame_vld}, 32'h1);
    chk("t1_bcd", o_bcd8d, 32'h12345678);
    chk("t1_lock", {31'b0, o_lock}, 32'h1);
    idle(2);
    chk("t1_vld_clr", {31'b0, o_frame_vld}, 32'h0);
    chk("t1_hold_bcd", o_bcd8d, 32'h12345678);
    chk("t1_hold_lock", {31'b0, o_lock}, 32'h1);

    // Start mid-scan at digit3, then a full frame of 9ABCD000.
    @(negedge i_clk) i_rst = 1'b1;
    @(negedge i_clk) i_rst = 1'b0;
    r_any_err = 1'b0;
    send_digit(3, 4'hd, 1'b0);
    send_digit(2, 4'h0, 1'b0);
    send_digit(1, 4'h0, 1'b0);
    send_digit(0, 4'h0, 1'b0);
    chk("t2_nolock", {31'b0, o_lock}, 32'h0);
    chk("t2_novld", {31'b0, o_frame_vld}, 32'h0);
    send_frame(32'h9ABCD000);
    chk("t2_noerr", {31'b0, r_any_err}, 32'h0);
    chk("t2_vld", {31'b0, o_frame_vld}, 32'h1);
    chk("t2_bcd", o_bcd8d, 32'h9ABCD000);

    // Bad common while locked.
    send_digit(7, 4'h1, 1'b0);
    sample(seg7(4'h2), 8'h81);
    chk("t3_err", {31'b0, o_err}, 32'h1);
    chk("t3_lock", {31'b0, o_lock}, 32'h0);
    chk("t3_bcd", o_bcd8d, 32'h9ABCD000);
    chk("t3_cnt", {24'b0, o_err_cnt}, 32'(c_CNT_ON));
    idle(1);
    chk("t3_err_clr", {31'b0, o_err}, 32'h0);

    // A wrong-index digit7 sample errors and does not restart a frame.
    send_digit(7, 4'h3, 1'b0);
    chk("t3b_lock", {31'b0, o_lock}, 32'h1);
    send_digit(7, 4'h3, 1'b0);
    chk("t3b_err", {31'b0, o_err}, 32'h1);
    chk("t3b_unlock", {31'b0, o_lock}, 32'h0);
    send_digit(6, 4'h4, 1'b0);
    chk("t3b_noreuse", {31'b0, o_lock}, 32'h0);
    chk("t3b_cnt", {24'b0, o_err_cnt}, 32'(2 * c_CNT_ON));

    // Blank runs: three are tolerated, the counter clears, four drop lock.
    send_frame(32'h87654321);
    chk("t4_bcd", o_bcd8d, 32'h87654321);
    repeat (3) sample(8'h3f, 8'h00);
    chk("t4_lock3", {31'b0, o_lock}, 32'h1);
    send_digit(7, 4'h5, 1'b0);
    repeat (3) sample(8'h3f, 8'h00);
    chk("t4_lock3b", {31'b0, o_lock}, 32'h1);
    r_any_err = 1'b0;
    sample(8'h3f, 8'h00);
    chk("t4_unlock", {31'b0, o_lock}, 32'h0);
    chk("t4_noerr", {31'b0, r_any_err}, 32'h0);
    chk("t4_bcd_keep", o_bcd8d, 32'h87654321);
    send_frame(32'h0000_0000);
    chk("t4_vld", {31'b0, o_frame_vld}, 32'h1);
    chk("t4_bcd0", o_bcd8d, 32'h0);
    chk("t4_relock", {31'b0, o_lock}, 32'h1);

    // Unknown pattern, then an asynchronous reset mid-frame.
    send_digit(7, 4'h1, 1'b0);
    send_digit(6, 4'h2, 1'b0);
    sample(8'h55, 8'h20);
    chk("t5_err", {31'b0, o_err}, 32'h1);
    chk("t5_lock", {31'b0, o_lock}, 32'h0);
    chk("t5_cnt", {24'b0, o_err_cnt}, 32'(3 * c_CNT_ON));
    send_digit(7, 4'h4, 1'b0);
    send_digit(6, 4'h5, 1'b0);
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    chk_all_zero("t5_rst");
    @(negedge i_clk) i_rst = 1'b0;
    for (int d = 6; d >= 0; d--) send_digit(d, 4'h6, 1'b0);
    chk("t5_nolock", {31'b0, o_lock}, 32'h0);
    chk("t5_novld", {31'b0, o_frame_vld}, 32'h0);
    send_frame(32'h13579BD0);
    chk("t5_vld", {31'b0, o_frame_vld}, 32'h1);
    chk("t5_bcd", o_bcd8d, 32'h13579BD0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
